// File: rtl/inst_rom_arb.sv
// Instruction ROM arbiter: lets a loader take over the ROM for a write burst while
// the fetch pipeline is held, then flushes the pipeline and restarts the PC at 0.
module inst_rom_arb #(
  parameter int unsigned ROM_WORDS = 4096
) (
  input  logic        i_Clk,
  input  logic        i_reset,
  input  logic [31:0] i_fetch_addr,
  input  logic        i_ld_req,
  input  logic        i_ld_valid,
  input  logic [31:0] i_ld_addr,
  input  logic [31:0] i_ld_data,
  input  logic        i_ld_last,
  output logic        o_ld_ready,
  output logic        o_rom_we,
  output logic [31:0] o_rom_w_addr,
  output logic [31:0] o_rom_w_data,
  output logic [31:0] o_rom_r_addr,
  output logic [1:0]  o_hold_flag,
  output logic        o_pc_restart,
  output logic [15:0] o_ld_count,
  output logic        o_ld_err,
  output logic        o_busy
);

  localparam logic [1:0] StRun   = 2'd0;
  localparam logic [1:0] StDrain = 2'd1;
  localparam logic [1:0] StLoad  = 2'd2;
  localparam logic [1:0] StFlush = 2'd3;

  localparam logic [1:0] HoldNone  = 2'b00;
  localparam logic [1:0] HoldIfId  = 2'b01;
  localparam logic [1:0] FlushIfId = 2'b10;

  logic [1:0]  state_q, state_d;
  logic [15:0] count_q, count_d;
  logic        err_q, err_d;

  logic accept;
  logic addr_ok;
  logic wr;

  assign accept  = (state_q == StLoad) && i_ld_valid;
  assign addr_ok = (i_ld_addr[1:0] == 2'b00) && ({2'b00, i_ld_addr[31:2]} < ROM_WORDS);
  assign wr      = accept && addr_ok;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    err_d   = err_q;
    case (state_q)
      StRun: begin
        if (i_ld_req) begin
          state_d = StDrain;
          count_d = 16'd0;
          err_d   = 1'b0;
        end
      end
      StDrain: state_d = StLoad;
      StLoad: begin
        // An accepted last word wins over a dropped request, so it is not an abort.
        if (accept && i_ld_last) begin
          state_d = StFlush;
        end else if (!i_ld_req) begin
          state_d = StFlush;
          err_d   = 1'b1;
        end
      end
      default: state_d = StRun;
    endcase
    if (accept && !addr_ok) err_d = 1'b1;
    if (wr && (count_q != 16'hFFFF)) count_d = count_q + 16'd1;
  end

  always_ff @(posedge i_Clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= StRun;
      count_q <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    o_hold_flag = HoldNone;
    case (state_q)
      StDrain, StLoad: o_hold_flag = HoldIfId;
      StFlush:         o_hold_flag = FlushIfId;
      default:         o_hold_flag = HoldNone;
    endcase
  end

  // Read address always follows the PC; it is frozen anyway while the pipeline holds.
  assign o_rom_r_addr = i_fetch_addr;
  assign o_ld_ready   = (state_q == StLoad);
  assign o_rom_we     = wr;
  assign o_rom_w_addr = wr ? i_ld_addr : 32'd0;
  assign o_rom_w_data = wr ? i_ld_data : 32'd0;
  assign o_pc_restart = (state_q == StFlush);
  assign o_busy       = (state_q != StRun);
  assign o_ld_count   = count_q;
  assign o_ld_err     = err_q;

endmodule

// File: tb/tb_inst_rom_arb.sv
// Directed bench for inst_rom_arb: normal burst, bad addresses, abort, back-to-back
// bursts and reset during a burst.
module tb_inst_rom_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_addr;
  logic        ld_req, ld_valid, ld_last;
  logic [31:0] ld_addr, ld_data;
  logic        ld_ready, rom_we, pc_restart, ld_err, busy;
  logic [31:0] rom_w_addr, rom_w_data, rom_r_addr;
  logic [1:0]  hold_flag;
  logic [15:0] ld_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  inst_rom_arb #(.ROM_WORDS(4096)) dut (
    .i_Clk       (clk),
    .i_reset     (rst),
    .i_fetch_addr(fetch_addr),
    .i_ld_req    (ld_req),
    .i_ld_valid  (ld_valid),
    .i_ld_addr   (ld_addr),
    .i_ld_data   (ld_data),
    .i_ld_last   (ld_last),
    .o_ld_ready  (ld_ready),
    .o_rom_we    (rom_we),
    .o_rom_w_addr(rom_w_addr),
    .o_rom_w_data(rom_w_data),
    .o_rom_r_addr(rom_r_addr),
    .o_hold_flag (hold_flag),
    .o_pc_restart(pc_restart),
    .o_ld_count  (ld_count),
    .o_ld_err    (ld_err),
    .o_busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs and checks happen 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_word(input logic [31:0] a, input logic [31:0] d, input logic last);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    ld_last  = last;
    #1;
  endtask

  task automatic idle_word();
    ld_valid = 1'b0;
    ld_addr  = 32'd0;
    ld_data  = 32'd0;
    ld_last  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    fetch_addr = 32'h0000_0040;
    ld_req = 1'b0;
    idle_word();
    #12;
    check("rst_busy", busy, 0);
    check("rst_hold", hold_flag, 2'b00);
    check("rst_ready", ld_ready, 0);
    check("rst_we", rom_we, 0);
    check("rst_count", ld_count, 0);
    check("rst_err", ld_err, 0);
    check("rst_restart", pc_restart, 0);
    rst = 1'b0;
    tick();
    check("run_raddr", rom_r_addr, 32'h40);

    // Normal 3-word burst
    ld_req = 1'b1;
    #1;
    check("run_hold", hold_flag, 2'b00);
    check("run_ready", ld_ready, 0);
    tick();
    check("drain_hold", hold_flag, 2'b01);
    check("drain_ready", ld_ready, 0);
    check("drain_busy", busy, 1);
    tick();
    check("load_ready", ld_ready, 1);
    check("load_hold", hold_flag, 2'b01);
    check("load_raddr", rom_r_addr, 32'h40);
    drive_word(32'h0, 32'hAAAA_0000, 1'b0);
    check("w0_we", rom_we, 1);
    check("w0_addr", rom_w_addr, 32'h0);
    check("w0_data", rom_w_data, 32'hAAAA_0000);
    tick();
    check("w0_count", ld_count, 1);
    drive_word(32'h4, 32'hAAAA_0004, 1'b0);
    check("w1_we", rom_we, 1);
    tick();
    drive_word(32'h8, 32'hAAAA_0008, 1'b1);
    check("w2_we", rom_we, 1);
    check("w2_data", rom_w_data, 32'hAAAA_0008);
    tick();
    idle_word();
    ld_req = 1'b0;
    #1;
    check("flush_hold", hold_flag, 2'b10);
    check("flush_restart", pc_restart, 1);
    check("flush_ready", ld_ready, 0);
    check("b1_count", ld_count, 3);
    check("b1_err", ld_err, 0);
    tick();
    check("b1_run_busy", busy, 0);
    check("b1_run_restart", pc_restart, 0);
    check("b1_run_hold", hold_flag, 2'b00);

    // Misaligned and out-of-range words, then a good last word
    ld_req = 1'b1;
    tick();
    tick();
    drive_word(32'h2, 32'h1111_1111, 1'b0);
    check("mis_we", rom_we, 0);
    check("mis_waddr", rom_w_addr, 0);
    tick();
    check("mis_err", ld_err, 1);
    check("mis_count", ld_count, 0);
    drive_word(32'h4000, 32'h2222_2222, 1'b0);
    check("oor_we", rom_we, 0);
    check("oor_wdata", rom_w_data, 0);
    tick();
    drive_word(32'h10, 32'h3333_3333, 1'b1);
    check("b2_last_we", rom_we, 1);
    check("b2_last_addr", rom_w_addr, 32'h10);
    tick();
    idle_word();
    ld_req = 1'b0;
    #1;
    check("b2_count", ld_count, 1);
    check("b2_err", ld_err, 1);
    check("b2_restart", pc_restart, 1);
    tick();
    check("b2_hold_count", ld_count, 1);
    check("b2_hold_err", ld_err, 1);
    check("b2_run_busy", busy, 0);

    // Abort after two words
    ld_req = 1'b1;
    tick();
    check("b3_drain_count", ld_count, 0);
    check("b3_drain_err", ld_err, 0);
    tick();
    drive_word(32'h0, 32'h5, 1'b0);
    tick();
    drive_word(32'h4, 32'h6, 1'b0);
    tick();
    idle_word();
    ld_req = 1'b0;
    #1;
    check("abort_hold", hold_flag, 2'b01);
    check("abort_err_pre", ld_err, 0);
    tick();
    check("abort_restart", pc_restart, 1);
    check("abort_err", ld_err, 1);
    check("abort_count", ld_count, 2);
    tick();
    check("abort_run", busy, 0);

    // Request held high across FLUSH: exactly one RUN cycle, then a new DRAIN
    ld_req = 1'b1;
    tick();
    check("b4_drain_err", ld_err, 0);
    check("b4_drain_count", ld_count, 0);
    tick();
    drive_word(32'h0, 32'h7, 1'b1);
    tick();
    idle_word();
    #1;
    check("b4_flush", pc_restart, 1);
    check("b4_count", ld_count, 1);
    tick();
    check("gap_busy", busy, 0);
    check("gap_hold", hold_flag, 2'b00);
    tick();
    check("b5_drain_hold", hold_flag, 2'b01);
    check("b5_drain_count", ld_count, 0);
    tick();
    drive_word(32'h3FFC, 32'h9, 1'b0);
    check("top_word_we", rom_we, 1);
    check("top_word_addr", rom_w_addr, 32'h3FFC);
    tick();
    check("b5_count", ld_count, 1);

    // Reset in the middle of the burst, with a word still offered
    drive_word(32'h8, 32'hA, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_we", rom_we, 0);
    check("mid_rst_ready", ld_ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_hold", hold_flag, 2'b00);
    check("mid_rst_count", ld_count, 0);
    check("mid_rst_restart", pc_restart, 0);
    idle_word();
    ld_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_restart", pc_restart, 0);
    check("post_rst_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
